// File: rtl/eth_axis_frame_tx.sv
// Ethernet II frame builder: 14-byte header from latched fields, then payload
// from an internal byte buffer, onto an 8-bit AXI-stream. Padding/FCS added downstream.
module eth_axis_frame_tx #(
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned ADDR_WIDTH  = 11
) (
  input  logic                  logic_clk,
  input  logic                  logic_rst_n,
  input  logic                  buf_wr_en,
  input  logic [ADDR_WIDTH-1:0] buf_wr_addr,
  input  logic [7:0]            buf_wr_data,
  input  logic [47:0]           dst_mac,
  input  logic [47:0]           src_mac,
  input  logic [15:0]           ethertype,
  input  logic [ADDR_WIDTH-1:0] payload_len,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [15:0]           frames_sent,
  output logic [7:0]            tx_axis_tdata,
  output logic                  tx_axis_tvalid,
  input  logic                  tx_axis_tready,
  output logic                  tx_axis_tlast,
  output logic                  tx_axis_tuser
);

  localparam int unsigned           DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN  = ADDR_WIDTH'(MAX_PAYLOAD);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [3:0]            HDR_LAST = 4'd13;
  localparam logic [3:0]            HDR_PREV = 4'd12;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_TERM = 2'd3;

  logic [1:0]            state, state_n;
  logic                  busy_n, done_n, len_err_n;
  logic [15:0]           frames_n;
  logic [7:0]            tdata_n;
  logic                  tvalid_n, tlast_n, tuser_n;
  logic                  abort_flag, abort_flag_n;
  logic [3:0]            hdr_cnt, hdr_cnt_n;       // index of the header beat on the bus
  logic [103:0]          hdr_sr, hdr_sr_n;         // header bytes still to be presented
  logic [ADDR_WIDTH-1:0] pay_ptr, pay_ptr_n;       // payload index of the next beat to load
  logic [ADDR_WIDTH-1:0] len_q, len_n;
  logic [ADDR_WIDTH-1:0] rd_addr_c;

  logic [7:0] mem [DEPTH];
  logic [7:0] mem_q;                               // prefetch: always mem[pay_ptr]

  logic       hs_c;
  logic       in_hdr_c;
  logic [7:0] nxt_byte_c;

  assign hs_c       = tx_axis_tvalid & tx_axis_tready;
  assign in_hdr_c   = (state == S_HDR) && (hdr_cnt != HDR_LAST);
  assign nxt_byte_c = in_hdr_c ? hdr_sr[103:96] : mem_q;

  // Payload buffer write port; frozen while a frame is in flight
  always_ff @(posedge logic_clk) begin
    if (buf_wr_en && !busy) mem[buf_wr_addr] <= buf_wr_data;
  end

  // Synchronous read, addressed one beat ahead so the output never bubbles
  always_ff @(posedge logic_clk) begin
    mem_q <= mem[rd_addr_c];
  end

  // State and output registers
  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      len_err        <= 1'b0;
      frames_sent    <= 16'd0;
      tx_axis_tdata  <= 8'd0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tlast  <= 1'b0;
      tx_axis_tuser  <= 1'b0;
      abort_flag     <= 1'b0;
      hdr_cnt        <= 4'd0;
      hdr_sr         <= 104'd0;
      pay_ptr        <= '0;
      len_q          <= '0;
    end else begin
      state          <= state_n;
      busy           <= busy_n;
      done           <= done_n;
      len_err        <= len_err_n;
      frames_sent    <= frames_n;
      tx_axis_tdata  <= tdata_n;
      tx_axis_tvalid <= tvalid_n;
      tx_axis_tlast  <= tlast_n;
      tx_axis_tuser  <= tuser_n;
      abort_flag     <= abort_flag_n;
      hdr_cnt        <= hdr_cnt_n;
      hdr_sr         <= hdr_sr_n;
      pay_ptr        <= pay_ptr_n;
      len_q          <= len_n;
    end
  end

  // Next-state and next-beat logic
  always_comb begin
    state_n      = state;
    busy_n       = busy;
    done_n       = 1'b0;
    len_err_n    = 1'b0;
    frames_n     = frames_sent;
    tdata_n      = tx_axis_tdata;
    tvalid_n     = tx_axis_tvalid;
    tlast_n      = tx_axis_tlast;
    tuser_n      = tx_axis_tuser;
    abort_flag_n = abort_flag;
    hdr_cnt_n    = hdr_cnt;
    hdr_sr_n     = hdr_sr;
    pay_ptr_n    = pay_ptr;
    len_n        = len_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (payload_len > MAX_LEN) begin
            len_err_n = 1'b1;
          end else begin
            state_n      = S_HDR;
            busy_n       = 1'b1;
            tvalid_n     = 1'b1;
            tdata_n      = dst_mac[47:40];
            tlast_n      = 1'b0;
            tuser_n      = 1'b0;
            abort_flag_n = 1'b0;
            hdr_cnt_n    = 4'd0;
            hdr_sr_n     = {dst_mac[39:0], src_mac, ethertype};
            pay_ptr_n    = '0;
            len_n        = payload_len;
          end
        end
      end
      default: begin
        if (hs_c) begin
          if (tx_axis_tlast) begin
            // Frame complete; aborted frames are not counted
            state_n      = S_IDLE;
            busy_n       = 1'b0;
            done_n       = 1'b1;
            tvalid_n     = 1'b0;
            tlast_n      = 1'b0;
            tuser_n      = 1'b0;
            abort_flag_n = 1'b0;
            if (!tx_axis_tuser) frames_n = frames_sent + 16'd1;
          end else begin
            tdata_n = nxt_byte_c;
            if (abort_flag || abort) begin
              state_n = S_TERM;
              tlast_n = 1'b1;
              tuser_n = 1'b1;
            end else if (in_hdr_c) begin
              hdr_sr_n  = {hdr_sr[95:0], 8'h00};
              hdr_cnt_n = 4'(hdr_cnt + 4'd1);
              tlast_n   = (hdr_cnt == HDR_PREV) && (len_q == '0);
            end else begin
              state_n   = S_PAY;
              pay_ptr_n = pay_ptr + ONE;
              tlast_n   = (pay_ptr == len_q - ONE);
            end
          end
        end else if (abort) begin
          abort_flag_n = 1'b1;
        end
      end
    endcase

    rd_addr_c = pay_ptr_n;
  end

endmodule

// File: tb/tb_eth_axis_frame_tx.sv
// Directed bench for eth_axis_frame_tx: header/payload order, backpressure,
// abort, length limits, ignored start/writes while busy, reset mid-frame.
module tb_eth_axis_frame_tx;
  localparam int unsigned AW        = 11;
  localparam int          INJ_NONE  = 0;
  localparam int          INJ_ABORT = 1;
  localparam int          INJ_START = 2;
  localparam int          INJ_RST   = 3;

  logic logic_clk = 1'b0;
  always #5 logic_clk = ~logic_clk;

  logic          logic_rst_n;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [7:0]    buf_wr_data;
  logic [47:0]   dst_mac, src_mac;
  logic [15:0]   ethertype;
  logic [AW-1:0] payload_len;
  logic          start, abort;
  logic          busy, done, len_err;
  logic [15:0]   frames_sent;
  logic [7:0]    tx_axis_tdata;
  logic          tx_axis_tvalid, tx_axis_tready, tx_axis_tlast, tx_axis_tuser;

  eth_axis_frame_tx #(.MAX_PAYLOAD(1500), .ADDR_WIDTH(AW)) dut (
    .logic_clk(logic_clk), .logic_rst_n(logic_rst_n),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
    .payload_len(payload_len), .start(start), .abort(abort),
    .busy(busy), .done(done), .len_err(len_err), .frames_sent(frames_sent),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tvalid(tx_axis_tvalid),
    .tx_axis_tready(tx_axis_tready), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tuser(tx_axis_tuser)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_frames = 0;

  logic [7:0] pay_ref [0:2047];
  logic [7:0] exp_d [$];
  logic [7:0] cap_d [$];
  logic       cap_l [$];
  logic       cap_u [$];

  localparam logic [47:0] DST = 48'h01_02_03_04_05_06;
  localparam logic [47:0] SRC = 48'h0A_0B_0C_0D_0E_0F;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge logic_clk);
  endtask

  // kind 0: AA BB CC DD..., 1: incrementing, 2: i*7+3
  task automatic load_payload(input int len, input int kind);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      case (kind)
        0:       b = 8'(8'hAA + 8'(i * 17));
        1:       b = 8'(i);
        default: b = 8'(i * 7 + 3);
      endcase
      buf_wr_en   = 1'b1;
      buf_wr_addr = AW'(i);
      buf_wr_data = b;
      pay_ref[i]  = b;
      tick;
    end
    buf_wr_en = 1'b0;
  endtask

  task automatic build_exp(input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] et, input int len);
    exp_d.delete();
    for (int i = 0; i < 6; i++) exp_d.push_back(d[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_d.push_back(s[47 - 8*i -: 8]);
    exp_d.push_back(et[15:8]);
    exp_d.push_back(et[7:0]);
    for (int i = 0; i < len; i++) exp_d.push_back(pay_ref[i]);
  endtask

  task automatic run_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                           input int len, input bit rnd, input int inj_kind, input int inj_at);
    bit pv_v, pv_r, pv_l, pv_u, fin, hs, was_last, injected;
    logic [7:0] pv_d;
    int k;
    cap_d.delete(); cap_l.delete(); cap_u.delete();
    build_exp(d, s, et, len);
    dst_mac = d; src_mac = s; ethertype = et; payload_len = AW'(len);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_tvalid", 32'(tx_axis_tvalid), 1);
    chk("start_tdata", 32'(tx_axis_tdata), 32'(d[47:40]));
    k = 0; fin = 0; pv_v = 0; pv_r = 0; pv_l = 0; pv_u = 0; pv_d = 8'h00;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      if (pv_v && !pv_r) begin
        chk("stall_tvalid", 32'(tx_axis_tvalid), 1);
        chk("stall_tdata", 32'(tx_axis_tdata), 32'(pv_d));
        chk("stall_tlast", 32'(tx_axis_tlast), 32'(pv_l));
        chk("stall_tuser", 32'(tx_axis_tuser), 32'(pv_u));
      end
      if (inj_kind == INJ_RST && k == inj_at) begin
        logic_rst_n = 1'b0;
        tick;
        chk("rst_tvalid", 32'(tx_axis_tvalid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frames", 32'(frames_sent), 0);
        chk("rst_tlast", 32'(tx_axis_tlast), 0);
        exp_frames  = 0;
        logic_rst_n = 1'b1;
        tick;
        fin = 1;
      end else begin
        tx_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        hs       = tx_axis_tvalid && tx_axis_tready;
        was_last = hs && tx_axis_tlast;
        injected = 0;
        if (hs) begin
          cap_d.push_back(tx_axis_tdata);
          cap_l.push_back(tx_axis_tlast);
          cap_u.push_back(tx_axis_tuser);
          if (inj_kind == INJ_ABORT && k == inj_at) abort = 1'b1;
          if (inj_kind == INJ_START && k == inj_at) begin
            start = 1'b1; payload_len = AW'(2); dst_mac = ~d;
            buf_wr_en = 1'b1; buf_wr_addr = '0; buf_wr_data = 8'h55;
            injected = 1;
          end
          k++;
        end
        pv_v = tx_axis_tvalid; pv_r = tx_axis_tready; pv_d = tx_axis_tdata;
        pv_l = tx_axis_tlast;  pv_u = tx_axis_tuser;
        tick;
        abort = 1'b0;
        if (injected) begin
          chk("ign_start_len_err", 32'(len_err), 0);
          chk("ign_start_busy", 32'(busy), 1);
          start = 1'b0; buf_wr_en = 1'b0; dst_mac = d; payload_len = AW'(len);
        end
        if (was_last) begin
          chk("done_pulse", 32'(done), 1);
          chk("done_busy", 32'(busy), 0);
          chk("done_tvalid", 32'(tx_axis_tvalid), 0);
          if (inj_kind != INJ_ABORT) exp_frames++;
          chk("frames_sent", 32'(frames_sent), 32'(exp_frames));
          tick;
          chk("done_width", 32'(done), 0);
          fin = 1;
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
    tx_axis_tready = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int exp_n, input bit aborted);
    int n;
    chk({tag, "_count"}, 32'(cap_d.size()), 32'(exp_n));
    n = (cap_d.size() < exp_n) ? cap_d.size() : exp_n;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_tdata"}, 32'(cap_d[i]), 32'(exp_d[i]));
      chk({tag, "_tlast"}, 32'(cap_l[i]), 32'(i == exp_n - 1));
      chk({tag, "_tuser"}, 32'(cap_u[i]), 32'(aborted && (i == exp_n - 1)));
    end
  endtask

  initial begin
    logic_rst_n = 1'b0; buf_wr_en = 1'b0; buf_wr_addr = '0; buf_wr_data = 8'h00;
    dst_mac = '0; src_mac = '0; ethertype = '0; payload_len = '0;
    start = 1'b0; abort = 1'b0; tx_axis_tready = 1'b1;
    tick; tick;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_len_err", 32'(len_err), 0);
    chk("reset_frames", 32'(frames_sent), 0);
    chk("reset_tvalid", 32'(tx_axis_tvalid), 0);
    chk("reset_tdata", 32'(tx_axis_tdata), 0);
    chk("reset_tlast", 32'(tx_axis_tlast), 0);
    chk("reset_tuser", 32'(tx_axis_tuser), 0);
    logic_rst_n = 1'b1;
    tick;

    // Basic 4-byte frame
    load_payload(4, 0);
    chk("pay_ref_dd", 32'(pay_ref[3]), 32'h0000_00DD);
    run_frame(DST, SRC, 16'h0800, 4, 0, INJ_NONE, 0);
    check_frame("basic", 18, 0);

    // Abort coincident with the 5th handshake
    run_frame(DST, SRC, 16'h0800, 4, 0, INJ_ABORT, 4);
    check_frame("abort", 6, 1);
    chk("abort_frames", 32'(frames_sent), 1);

    // Abort in IDLE ignored, then zero-length frame
    abort = 1'b1; tick; abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_tvalid", 32'(tx_axis_tvalid), 0);
    run_frame(DST, SRC, 16'h88B5, 0, 0, INJ_NONE, 0);
    check_frame("zero_len", 14, 0);

    // Start and buffer write during a frame are ignored
    run_frame(DST, SRC, 16'h0800, 4, 0, INJ_START, 8);
    check_frame("busy_start", 18, 0);

    // Reset at beat 10, then resend from retained buffer
    run_frame(DST, SRC, 16'h0800, 4, 0, INJ_RST, 10);
    chk("rst_beats", 32'(cap_d.size()), 10);
    for (int i = 0; i < cap_d.size(); i++) begin
      chk("rst_partial_tdata", 32'(cap_d[i]), 32'(exp_d[i]));
      chk("rst_partial_tlast", 32'(cap_l[i]), 0);
    end
    run_frame(DST, SRC, 16'h0800, 4, 0, INJ_NONE, 0);
    check_frame("retained", 18, 0);
    chk("retained_byte0", 32'(cap_d[14]), 32'h0000_00AA);

    // Backpressure, 64-byte incrementing payload
    load_payload(64, 1);
    run_frame(DST, SRC, 16'h0800, 64, 1, INJ_NONE, 0);
    check_frame("backpressure", 78, 0);

    // Over-length start rejected
    payload_len = AW'(1501); start = 1'b1;
    tick;
    start = 1'b0;
    chk("len_err_pulse", 32'(len_err), 1);
    chk("len_err_tvalid", 32'(tx_axis_tvalid), 0);
    chk("len_err_busy", 32'(busy), 0);
    tick;
    chk("len_err_width", 32'(len_err), 0);
    chk("len_err_tvalid2", 32'(tx_axis_tvalid), 0);

    // Maximum-length frame
    load_payload(1500, 2);
    run_frame(DST, SRC, 16'h86DD, 1500, 0, INJ_NONE, 0);
    check_frame("max_len", 1514, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
